rpi_irq_scheduler: RTL

- Sequences the Raspberry Pi interrupt line for the DE2 I2S bridge.
- Generates the divided interrupt tick clock internally.
- Arbitrates round-robin between the left and right channel buffer service requests.
- Drives a single IRQ with an acknowledge handshake, timeout and post-service holdoff, so the RPi is never interrupted faster than the tick rate allows.

---
 rtl/rpi_irq_pkg.sv | 15 +
 rtl/rpi_tick_gen.sv | 32 +++
 rtl/rpi_irq_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rpi_irq_pkg.sv
// Shared types and constants for the RPi interrupt scheduler.
package rpi_irq_pkg;

    localparam int   TMR_W = 8;
    localparam logic SRC_L = 1'b0;
    localparam logic SRC_R = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_REL = 2'd2,
        HOLD     = 2'd3
    } irq_state_t;

endpackage

// File: rtl/rpi_tick_gen.sv
// Divides clk_in down to tick_clk and flags each rising tick_clk edge.
module rpi_tick_gen #(
    parameter int DIV_HALF = 32,
    parameter int CNT_W    = 17
) (
    input  logic clk_in,
    input  logic rst,
    output logic tick_clk,
    output logic tick_stb
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_HALF - 1);

    logic [CNT_W-1:0] count;

    // Half-period counter; the strobe rides along with the 0->1 toggle.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            count    <= '0;
            tick_clk <= 1'b0;
            tick_stb <= 1'b0;
        end else if (count == LAST) begin
            count    <= '0;
            tick_clk <= ~tick_clk;
            tick_stb <= ~tick_clk;
        end else begin
            count    <= count + 1'b1;
            tick_stb <= 1'b0;
        end
    end

endmodule

// File: rtl/rpi_irq_scheduler.sv
// Round-robin IRQ sequencer for the left/right I2S buffers, paced by tick_clk.
import rpi_irq_pkg::*;

module rpi_irq_scheduler #(
    parameter int DIV_HALF = 32,
    parameter int CNT_W    = 17,
    parameter int HOLDOFF  = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic clk_in,
    input  logic rst,
    input  logic interrupt_enable,
    input  logic req_l,
    input  logic req_r,
    input  logic rpi_ack,
    output logic irq_out,
    output logic irq_src,
    output logic grant_l,
    output logic grant_r,
    output logic timeout_pulse,
    output logic tick_clk,
    output logic busy
);

    localparam logic [TMR_W-1:0] HOLDOFF_T = TMR_W'(HOLDOFF);
    localparam logic [TMR_W-1:0] TIMEOUT_T = TMR_W'(TIMEOUT);

    logic tick_stb;

    rpi_tick_gen #(.DIV_HALF(DIV_HALF), .CNT_W(CNT_W)) u_tick (
        .clk_in   (clk_in),
        .rst      (rst),
        .tick_clk (tick_clk),
        .tick_stb (tick_stb)
    );

    // Ack synchronizer: two flops for metastability, third for edge detect.
    logic ack_s1, ack_s2, ack_s3;
    always_ff @(posedge clk_in) begin
        if (rst) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
            ack_s3 <= 1'b0;
        end else begin
            ack_s1 <= rpi_ack;
            ack_s2 <= ack_s1;
            ack_s3 <= ack_s2;
        end
    end

    logic ack_rise, ack_low;
    assign ack_rise = ack_s2 & ~ack_s3;
    assign ack_low  = ~ack_s2;

    irq_state_t       state, state_n;
    logic [TMR_W-1:0] timer, timer_n, timer_inc;
    logic             last_src, last_n;
    logic             irq_n, src_n, gl_n, gr_n, to_n, sel;

    // Saturating increment so a long stall can never wrap the timer.
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    // Both pending: alternate away from whoever was served last.
    assign sel = (req_l && req_r) ? ~last_src : req_r;

    // State and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            last_src      <= SRC_R;
            irq_out       <= 1'b0;
            irq_src       <= SRC_L;
            grant_l       <= 1'b0;
            grant_r       <= 1'b0;
            timeout_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            last_src      <= last_n;
            irq_out       <= irq_n;
            irq_src       <= src_n;
            grant_l       <= gl_n;
            grant_r       <= gr_n;
            timeout_pulse <= to_n;
            busy          <= (state_n != IDLE);
        end
    end

    // Next-state / next-output logic; HOLD is always entered with a cleared timer.
    always_comb begin
        state_n = state;
        timer_n = timer;
        last_n  = last_src;
        irq_n   = irq_out;
        src_n   = irq_src;
        gl_n    = 1'b0;
        gr_n    = 1'b0;
        to_n    = 1'b0;
        case (state)
            IDLE: begin
                if (tick_stb && interrupt_enable && (req_l || req_r)) begin
                    irq_n   = 1'b1;
                    src_n   = sel;
                    timer_n = '0;
                    state_n = ASSERT;
                end
            end
            ASSERT: begin
                if (!interrupt_enable) begin
                    irq_n   = 1'b0;
                    timer_n = '0;
                    state_n = HOLD;
                end else if (ack_rise) begin
                    irq_n   = 1'b0;
                    gl_n    = (irq_src == SRC_L);
                    gr_n    = (irq_src == SRC_R);
                    last_n  = irq_src;
                    state_n = WAIT_REL;
                end else if (tick_stb) begin
                    timer_n = timer_inc;
                    if (timer_inc >= TIMEOUT_T) begin
                        irq_n   = 1'b0;
                        to_n    = 1'b1;
                        last_n  = irq_src;
                        timer_n = '0;
                        state_n = HOLD;
                    end
                end
            end
            WAIT_REL: begin
                if (ack_low) begin
                    timer_n = '0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (timer == HOLDOFF_T)
                    state_n = IDLE;
                else if (tick_stb)
                    timer_n = timer_inc;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
